// File: rtl/axi_stream_rr_arbiter_if.sv
// Stream bundle between N sources, the arbiter and one downstream sink.
// slave: the arbiter's view; master: the surrounding sources and sink.
interface axi_stream_rr_arbiter_if #(
  parameter int N_INPUTS   = 3,
  parameter int DATA_WIDTH = 32
);
  logic [N_INPUTS-1:0]            in_valid;
  logic [N_INPUTS-1:0]            in_ready;
  logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [N_INPUTS*8-1:0]          in_dest;
  logic [N_INPUTS*8-1:0]          in_user;
  logic [N_INPUTS-1:0]            in_tlast;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [7:0]                     out_dest;
  logic [7:0]                     out_user;
  logic                           out_tlast;

  modport slave (
    input  in_valid, in_data, in_dest, in_user, in_tlast, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_user, out_tlast
  );

  modport master (
    output in_valid, in_data, in_dest, in_user, in_tlast, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_user, out_tlast
  );
endinterface

// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin arbiter merging N AXI-stream sources into one registered output,
// with bounded grants and per-source periodic tlast generation.
//
// state   | meaning
// IDLE    | searching in_valid from grant_id+1 for the next source
// GRANTED | forwarding beats of source grant_id until a release condition
module axi_stream_rr_arbiter #(
  parameter int N_INPUTS     = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int HOLD_BEATS   = 4,
  parameter int TLAST_PERIOD = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  axi_stream_rr_arbiter_if.slave bus,
  output logic [2:0]             grant_id,
  output logic                   grant_active
);

  localparam int BW = (HOLD_BEATS > 1) ? $clog2(HOLD_BEATS) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state, state_nxt;
  logic [2:0]            grant_nxt;
  logic [BW-1:0]         beat_cnt, beat_nxt;
  logic [15:0]           tcnt [N_INPUTS];

  logic                  g_valid, g_tlast;
  logic [DATA_WIDTH-1:0] g_data;
  logic [7:0]            g_dest, g_user;
  logic [15:0]           g_tcnt;
  logic                  can_load, accept, tlast_gen, beat_tlast, found;
  logic [N_INPUTS-1:0]   in_ready_c;

  logic                  out_valid_q, out_tlast_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [7:0]            out_dest_q, out_user_q;

  always_comb begin
    g_valid = 1'b0;
    g_tlast = 1'b0;
    g_data  = '0;
    g_dest  = '0;
    g_user  = '0;
    g_tcnt  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_id == 3'(i)) begin
        g_valid = bus.in_valid[i];
        g_tlast = bus.in_tlast[i];
        g_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_dest  = bus.in_dest[i*8 +: 8];
        g_user  = bus.in_user[i*8 +: 8];
        g_tcnt  = tcnt[i];
      end
    end
  end

  // The output register may only take a new beat if it is empty or draining.
  assign can_load   = ~out_valid_q | bus.out_ready;
  assign accept     = (state == GRANTED) & g_valid & can_load;
  assign tlast_gen  = (g_tcnt == 16'(TLAST_PERIOD - 1));
  assign beat_tlast = g_tlast | tlast_gen;

  always_comb begin
    in_ready_c = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      in_ready_c[i] = (state == GRANTED) && (grant_id == 3'(i)) && can_load;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    beat_nxt  = beat_cnt;
    found     = 1'b0;
    case (state)
      IDLE: begin
        for (int k = 1; k <= N_INPUTS; k++) begin
          for (int j = 0; j < N_INPUTS; j++) begin
            if (!found && (j == (int'(grant_id) + k) % N_INPUTS) && bus.in_valid[j]) begin
              found     = 1'b1;
              grant_nxt = 3'(j);
            end
          end
        end
        if (found) begin
          state_nxt = GRANTED;
          beat_nxt  = '0;
        end
      end
      GRANTED: begin
        if (accept) begin
          beat_nxt = BW'(beat_cnt + 1'b1);
          if ((beat_cnt == BW'(HOLD_BEATS - 1)) || beat_tlast) begin
            state_nxt = IDLE;
          end
        end else if (!g_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= 3'(N_INPUTS - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Only the granted source's counter moves; it wraps when it generates tlast.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) tcnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (grant_id == 3'(i)) tcnt[i] <= tlast_gen ? 16'd0 : 16'(tcnt[i] + 16'd1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_user_q  <= '0;
      out_tlast_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= g_data;
      out_dest_q  <= g_dest;
      out_user_q  <= g_user;
      out_tlast_q <= beat_tlast;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dest  = out_dest_q;
  assign bus.out_user  = out_user_q;
  assign bus.out_tlast = out_tlast_q;
  assign grant_active  = (state == GRANTED);

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for the round-robin stream arbiter (N=3, HOLD_BEATS=4, TLAST_PERIOD=8).
// Source i sends data {i, seq}, dest 16+i, and counts its own accepted beats.
module tb_axi_stream_rr_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;

  logic       clock;
  logic       reset;
  logic [2:0] grant_id;
  logic       grant_active;

  axi_stream_rr_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(DW)) bus ();

  axi_stream_rr_arbiter #(
    .N_INPUTS(N), .DATA_WIDTH(DW), .HOLD_BEATS(4), .TLAST_PERIOD(8)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .grant_id(grant_id), .grant_active(grant_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int seq   [N];
  int len   [N];
  int tl_at [N];
  int b_src[$], b_seq[$], b_tlast[$], b_cyc[$], b_dest[$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]           = (seq[i] < len[i]);
      bus.in_data[i*DW +: DW]   = {8'(i), 24'(seq[i])};
      bus.in_dest[i*8 +: 8]     = 8'(16 + i);
      bus.in_user[i*8 +: 8]     = 8'(seq[i]);
      bus.in_tlast[i]           = (seq[i] == tl_at[i]);
    end
  endtask

  // One clock: record a draining output beat, advance sources whose beat was taken.
  task automatic tick();
    logic [N-1:0] fire;
    #1;
    fire = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      b_src.push_back(int'(bus.out_data[31:24]));
      b_seq.push_back(int'(bus.out_data[23:0]));
      b_tlast.push_back(int'(bus.out_tlast));
      b_dest.push_back(int'(bus.out_dest));
      b_cyc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (fire[i]) seq[i]++;
    drive();
    #1;
  endtask

  task automatic run_until(int nbeats, int max_cyc);
    for (int c = 0; c < max_cyc && b_src.size() < nbeats; c++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; len[i] = 0; tl_at[i] = -1;
    end
    drive();
    repeat (3) tick();
    reset = 1'b0;
    b_src.delete(); b_seq.delete(); b_tlast.delete(); b_cyc.delete(); b_dest.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; len[i] = 100; tl_at[i] = -1;
    end
    drive();
    repeat (5) tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 3'b000) $display("FAIL reset_in_ready: got %b expected 000", bus.in_ready); else n_pass++;
    n_checks++; if (grant_id !== 3'd2) $display("FAIL reset_grant_id: got %0d expected 2", grant_id); else n_pass++;
    n_checks++; if (grant_active !== 1'b0) $display("FAIL reset_grant_active: got %b expected 0", grant_active); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (grant_id !== 3'd0) $display("FAIL first_grant_id: got %0d expected 0", grant_id); else n_pass++;
    n_checks++; if (grant_active !== 1'b1) $display("FAIL first_grant_active: got %b expected 1", grant_active); else n_pass++;
    n_checks++; if (bus.in_ready !== 3'b001) $display("FAIL first_in_ready: got %b expected 001", bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0000)
      $display("FAIL first_beat: got valid %b data %h expected valid 1 data 00000000", bus.out_valid, bus.out_data); else n_pass++;
  endtask

  task automatic test_fairness();
    int exp_seq;
    do_reset();
    for (int i = 0; i < N; i++) len[i] = 100;
    drive();
    run_until(24, 80);
    n_checks++; if (b_src.size() < 24) $display("FAIL fair_timeout: got %0d beats expected 24", b_src.size()); else n_pass++;
    for (int k = 0; k < 24 && k < b_src.size(); k++) begin
      exp_seq = (k / 12) * 4 + (k % 4);
      n_checks++; if (b_src[k] != (k / 4) % 3) $display("FAIL fair_src[%0d]: got %0d expected %0d", k, b_src[k], (k / 4) % 3); else n_pass++;
      n_checks++; if (b_seq[k] != exp_seq) $display("FAIL fair_seq[%0d]: got %0d expected %0d", k, b_seq[k], exp_seq); else n_pass++;
      n_checks++; if (b_dest[k] != 16 + (k / 4) % 3) $display("FAIL fair_dest[%0d]: got %0d expected %0d", k, b_dest[k], 16 + (k / 4) % 3); else n_pass++;
      n_checks++; if (b_tlast[k] != int'(exp_seq == 7)) $display("FAIL fair_tlast[%0d]: got %0d expected %0d", k, b_tlast[k], int'(exp_seq == 7)); else n_pass++;
      if (k > 0) begin
        n_checks++; if (b_cyc[k] - b_cyc[k-1] != ((k % 4 == 0) ? 2 : 1))
          $display("FAIL fair_gap[%0d]: got %0d expected %0d", k, b_cyc[k] - b_cyc[k-1], (k % 4 == 0) ? 2 : 1); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int pat [16] = '{1,0,0,1,0,1,1,0,0,0,1,1,1,0,1,1};
    logic        stalled_prev;
    logic [31:0] data_prev;
    int          stall_seen;
    do_reset();
    len[1] = 4;
    drive();
    stalled_prev = 1'b0;
    data_prev    = '0;
    stall_seen   = 0;
    for (int c = 0; c < 40 && b_src.size() < 4; c++) begin
      bus.out_ready = pat[c % 16][0];
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        n_checks++; if (bus.in_ready !== 3'b000) $display("FAIL bp_in_ready_c%0d: got %b expected 000", c, bus.in_ready); else n_pass++;
        if (stalled_prev) begin
          stall_seen++;
          n_checks++; if (bus.out_data !== data_prev) $display("FAIL bp_stable_c%0d: got %h expected %h", c, bus.out_data, data_prev); else n_pass++;
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      data_prev    = bus.out_data;
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    n_checks++; if (stall_seen == 0) $display("FAIL bp_stall_exercised: got 0 held stalls expected at least 1"); else n_pass++;
    n_checks++; if (b_src.size() != 4) $display("FAIL bp_beat_count: got %0d expected 4", b_src.size()); else n_pass++;
    for (int k = 0; k < 4 && k < b_src.size(); k++) begin
      n_checks++; if (b_src[k] != 1 || b_seq[k] != k)
        $display("FAIL bp_beat[%0d]: got src %0d seq %0d expected src 1 seq %0d", k, b_src[k], b_seq[k], k); else n_pass++;
    end
  endtask

  task automatic test_gen_tlast();
    do_reset();
    len[2] = 24;
    drive();
    run_until(24, 80);
    n_checks++; if (b_src.size() < 24) $display("FAIL gtl_timeout: got %0d beats expected 24", b_src.size()); else n_pass++;
    for (int k = 0; k < 24 && k < b_src.size(); k++) begin
      n_checks++; if (b_src[k] != 2 || b_seq[k] != k)
        $display("FAIL gtl_beat[%0d]: got src %0d seq %0d expected src 2 seq %0d", k, b_src[k], b_seq[k], k); else n_pass++;
      n_checks++; if (b_tlast[k] != int'(k % 8 == 7)) $display("FAIL gtl_tlast[%0d]: got %0d expected %0d", k, b_tlast[k], int'(k % 8 == 7)); else n_pass++;
    end
  endtask

  task automatic test_input_tlast();
    int e_src   [17] = '{0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0, 1};
    int e_seq   [17] = '{0,1, 0,1,2,3, 2,3,4,5, 4,5,6,7, 6,7, 8};
    int e_tlast [17] = '{0,1, 0,0,0,0, 0,0,0,0, 0,0,0,1, 0,1, 0};
    do_reset();
    len[0] = 100; tl_at[0] = 1;
    len[1] = 100;
    drive();
    run_until(17, 80);
    n_checks++; if (b_src.size() < 17) $display("FAIL itl_timeout: got %0d beats expected 17", b_src.size()); else n_pass++;
    for (int k = 0; k < 17 && k < b_src.size(); k++) begin
      n_checks++; if (b_src[k] != e_src[k] || b_seq[k] != e_seq[k] || b_tlast[k] != e_tlast[k])
        $display("FAIL itl_beat[%0d]: got src %0d seq %0d tlast %0d expected src %0d seq %0d tlast %0d",
                 k, b_src[k], b_seq[k], b_tlast[k], e_src[k], e_seq[k], e_tlast[k]); else n_pass++;
    end
    if (b_cyc.size() >= 17) begin
      n_checks++; if (b_cyc[2] - b_cyc[1] != 2) $display("FAIL itl_bubble_after_in_tlast: got %0d expected 2", b_cyc[2] - b_cyc[1]); else n_pass++;
      n_checks++; if (b_cyc[16] - b_cyc[15] != 2) $display("FAIL itl_bubble_after_gen_tlast: got %0d expected 2", b_cyc[16] - b_cyc[15]); else n_pass++;
    end
  endtask

  task automatic test_idle_release();
    int e_src [6] = '{1,2,2,0,0,1};
    int e_seq [6] = '{0,0,1,0,1,1};
    logic enabled;
    do_reset();
    len[1] = 1;
    len[2] = 2;
    drive();
    enabled = 1'b0;
    for (int c = 0; c < 60 && b_src.size() < 6; c++) begin
      tick();
      if (!enabled && b_src.size() >= 2) begin
        enabled = 1'b1;
        n_checks++; if (grant_id !== 3'd2) $display("FAIL idle_grant_id: got %0d expected 2", grant_id); else n_pass++;
        len[0] = 2;
        len[1] = 2;
        drive();
        #1;
      end
    end
    n_checks++; if (b_src.size() < 6) $display("FAIL idle_timeout: got %0d beats expected 6", b_src.size()); else n_pass++;
    for (int k = 0; k < 6 && k < b_src.size(); k++) begin
      n_checks++; if (b_src[k] != e_src[k] || b_seq[k] != e_seq[k])
        $display("FAIL idle_beat[%0d]: got src %0d seq %0d expected src %0d seq %0d", k, b_src[k], b_seq[k], e_src[k], e_seq[k]); else n_pass++;
    end
    if (b_cyc.size() >= 2) begin
      n_checks++; if (b_cyc[1] - b_cyc[0] != 3) $display("FAIL idle_release_gap: got %0d expected 3", b_cyc[1] - b_cyc[0]); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.in_user   = '0;
    bus.in_tlast  = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_gen_tlast();
    test_input_tlast();
    test_idle_release();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
